// File: rtl/exc_pkg.sv
// Shared encodings for the exception commit controller: ExcCodes, mem_exc
// bit positions, FSM states and the captured-event flag bundle.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // mem_exc = {ades, adel_ld, bp, sys, ov, ri, adel_if}
  localparam int EXC_W      = 7;
  localparam int EB_ADEL_IF = 0;
  localparam int EB_RI      = 1;
  localparam int EB_OV      = 2;
  localparam int EB_SYS     = 3;
  localparam int EB_BP      = 4;
  localparam int EB_ADEL_LD = 5;
  localparam int EB_ADES    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_ADDR = 2'd2
  } bv_sel_t;

  // What the FLUSH cycle needs to know about the captured event
  typedef struct packed {
    logic eret;
    logic epc_en;
    logic bv_en;
  } cap_t;

endpackage

// File: rtl/exc_prio.sv
// Priority encoder: interrupt beats every exception, exceptions beat ERET.
module exc_prio
  import exc_pkg::*;
(
  input  logic             irq,
  input  logic [EXC_W-1:0] exc,
  input  logic             eret,
  output logic             taken,
  output logic             is_eret,
  output logic [4:0]       exccode,
  output bv_sel_t          bv_sel
);

  always_comb begin
    taken   = irq | (|exc) | eret;
    is_eret = 1'b0;
    exccode = EXC_INT;
    bv_sel  = BV_NONE;
    if (irq) begin
      exccode = EXC_INT;
    end else if (exc[EB_ADEL_IF]) begin
      exccode = EXC_ADEL;
      bv_sel  = BV_PC;
    end else if (exc[EB_RI]) begin
      exccode = EXC_RI;
    end else if (exc[EB_OV]) begin
      exccode = EXC_OV;
    end else if (exc[EB_SYS]) begin
      exccode = EXC_SYS;
    end else if (exc[EB_BP]) begin
      exccode = EXC_BP;
    end else if (exc[EB_ADEL_LD]) begin
      exccode = EXC_ADEL;
      bv_sel  = BV_ADDR;
    end else if (exc[EB_ADES]) begin
      exccode = EXC_ADES;
      bv_sel  = BV_ADDR;
    end else if (eret) begin
      is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// Exception commit controller at MEM/WB: captures the winning event, pulses
// CP0 write strobes and flush for one cycle, then holds a redirect to fetch.
module exc_commit
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_OFFSET = 32'h0000_0180,
  parameter logic [31:0] EPC_ADJ    = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc,
  input  logic             mem_in_ds,
  input  logic [EXC_W-1:0] mem_exc,
  input  logic [31:0]      mem_badvaddr,
  input  logic             mem_eret,
  input  logic             soft_break,
  input  logic             hard_break,
  input  logic             status_exl,
  input  logic [31:0]      epc_in,
  input  logic [31:0]      ebase_in,
  output logic             set_status_exl,
  output logic             clr_status_exl,
  output logic             badvaddr_wr,
  output logic [31:0]      badvaddr_out,
  output logic             cause_bd_wr,
  output logic             cause_bd,
  output logic             cause_exccode_wr,
  output logic [4:0]       cause_exccode,
  output logic             epc_wr,
  output logic [31:0]      set_epc,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready
);

  state_t     state, state_nx;
  cap_t       cap;
  logic       capture;
  logic       p_taken, p_eret;
  logic [4:0] p_code;
  bv_sel_t    p_bv;

  exc_prio u_prio (
    .irq     (soft_break | hard_break),
    .exc     (mem_exc),
    .eret    (mem_eret),
    .taken   (p_taken),
    .is_eret (p_eret),
    .exccode (p_code),
    .bv_sel  (p_bv)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Data outputs are written only at capture and held until the next one;
  // an ERET only retargets the redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap           <= '0;
      cause_bd      <= 1'b0;
      cause_exccode <= '0;
      set_epc       <= '0;
      badvaddr_out  <= '0;
      redirect_pc   <= '0;
    end else if (capture) begin
      cap.eret    <= p_eret;
      cap.epc_en  <= ~status_exl;
      cap.bv_en   <= (p_bv != BV_NONE);
      redirect_pc <= p_eret ? epc_in : ebase_in + EXC_OFFSET;
      if (!p_eret) begin
        cause_bd      <= mem_in_ds;
        cause_exccode <= p_code;
        set_epc       <= mem_in_ds ? mem_pc - EPC_ADJ : mem_pc;
      end
      if (p_bv == BV_PC)        badvaddr_out <= mem_pc;
      else if (p_bv == BV_ADDR) badvaddr_out <= mem_badvaddr;
    end
  end

  always_comb begin
    state_nx         = state;
    capture          = 1'b0;
    flush            = 1'b0;
    set_status_exl   = 1'b0;
    clr_status_exl   = 1'b0;
    cause_exccode_wr = 1'b0;
    epc_wr           = 1'b0;
    cause_bd_wr      = 1'b0;
    badvaddr_wr      = 1'b0;
    redirect_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid && p_taken) begin
          capture  = 1'b1;
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cap.eret) begin
          clr_status_exl = 1'b1;
        end else begin
          set_status_exl   = 1'b1;
          cause_exccode_wr = 1'b1;
          // nested exception under EXL keeps the original EPC/BD
          epc_wr           = cap.epc_en;
          cause_bd_wr      = cap.epc_en;
          badvaddr_wr      = cap.bv_en;
        end
        state_nx = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench for exc_commit: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_in_ds, mem_eret, soft_break, hard_break, status_exl;
  logic [31:0] mem_pc, mem_badvaddr, epc_in, ebase_in;
  logic [6:0]  mem_exc;
  logic        redirect_ready;
  logic        set_status_exl, clr_status_exl, badvaddr_wr, cause_bd_wr, cause_bd;
  logic        cause_exccode_wr, epc_wr, flush, redirect_valid;
  logic [31:0] badvaddr_out, set_epc, redirect_pc;
  logic [4:0]  cause_exccode;

  always #5 clk = ~clk;

  exc_commit dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_ds(mem_in_ds),
    .mem_exc(mem_exc), .mem_badvaddr(mem_badvaddr), .mem_eret(mem_eret),
    .soft_break(soft_break), .hard_break(hard_break), .status_exl(status_exl),
    .epc_in(epc_in), .ebase_in(ebase_in),
    .set_status_exl(set_status_exl), .clr_status_exl(clr_status_exl),
    .badvaddr_wr(badvaddr_wr), .badvaddr_out(badvaddr_out),
    .cause_bd_wr(cause_bd_wr), .cause_bd(cause_bd),
    .cause_exccode_wr(cause_exccode_wr), .cause_exccode(cause_exccode),
    .epc_wr(epc_wr), .set_epc(set_epc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for an event, 1 = the cycle after capture,
  // 2 = redirect outstanding. Cause priority follows bit order of mem_exc.
  logic [4:0]  code_tab [7] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
  int          phase = 0;
  int          k_m;
  logic        m_exc, m_exl, m_bvw, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bv, m_rpc;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; m_exc = 0; m_exl = 0; m_bvw = 0; m_bd = 0;
      m_code = 0; m_epc = 0; m_bv = 0; m_rpc = 0;
    end else begin
      case (phase)
        0: if (mem_valid && (soft_break || hard_break || mem_exc != 0 || mem_eret)) begin
             phase = 1;
             m_exl = status_exl;
             m_exc = soft_break || hard_break || mem_exc != 0;
             if (m_exc) begin
               m_bd  = mem_in_ds;
               m_epc = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
               m_rpc = ebase_in + 32'h180;
               m_bvw = 1'b0;
               if (soft_break || hard_break) m_code = 5'h00;
               else begin
                 k_m = 0;
                 while (!mem_exc[k_m]) k_m++;
                 m_code = code_tab[k_m];
                 if (k_m == 0) begin m_bv = mem_pc; m_bvw = 1'b1; end
                 else if (k_m >= 5) begin m_bv = mem_badvaddr; m_bvw = 1'b1; end
               end
             end else begin
               m_rpc = epc_in;
             end
           end
        1: phase = 2;
        default: if (redirect_ready) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("flush",    32'(flush),            32'(phase == 1));
      chk("set_exl",  32'(set_status_exl),   32'(phase == 1 && m_exc));
      chk("clr_exl",  32'(clr_status_exl),   32'(phase == 1 && !m_exc));
      chk("code_wr",  32'(cause_exccode_wr), 32'(phase == 1 && m_exc));
      chk("epc_wr",   32'(epc_wr),           32'(phase == 1 && m_exc && !m_exl));
      chk("bd_wr",    32'(cause_bd_wr),      32'(phase == 1 && m_exc && !m_exl));
      chk("bv_wr",    32'(badvaddr_wr),      32'(phase == 1 && m_exc && m_bvw));
      chk("rvalid",   32'(redirect_valid),   32'(phase == 2));
      chk("exccode",  32'(cause_exccode),    32'(m_code));
      chk("bd",       32'(cause_bd),         32'(m_bd));
      chk("set_epc",  set_epc,               m_epc);
      chk("badvaddr", badvaddr_out,          m_bv);
      chk("rpc",      redirect_pc,           m_rpc);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_valid = 0; mem_exc = 0; mem_eret = 0; soft_break = 0; hard_break = 0;
  endtask

  // Present one event for a single edge; returns in the strobe cycle
  task automatic ev(input logic [31:0] pc, input logic ds, input logic [6:0] e,
                    input logic [31:0] bva, input logic er, input logic hb, input logic exl);
    mem_valid = 1; mem_pc = pc; mem_in_ds = ds; mem_exc = e; mem_badvaddr = bva;
    mem_eret = er; hard_break = hb; status_exl = exl;
    step();
    idle_in();
  endtask

  initial begin
    rst = 1; idle_in(); mem_pc = 0; mem_in_ds = 0; mem_badvaddr = 0; status_exl = 0;
    epc_in = 0; ebase_in = 32'h8000_1000; redirect_ready = 1;
    step(); step();
    chk_on = 1'b1;
    rst = 0;
    @(negedge clk);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst_epc", set_epc, 32'd0);

    // Ov, not in delay slot
    ev(32'hBFC0_0100, 0, 7'b0000100, 32'h0, 0, 0, 0);
    @(negedge clk);
    chk("ov_flush", 32'(flush), 32'd1);
    chk("ov_code", 32'(cause_exccode), 32'h0C);
    chk("ov_epc_wr", 32'(epc_wr), 32'd1);
    chk("ov_epc", set_epc, 32'hBFC0_0100);
    chk("ov_bd", 32'(cause_bd), 32'd0);
    chk("ov_bv_wr", 32'(badvaddr_wr), 32'd0);
    step(); @(negedge clk);
    chk("ov_rvalid", 32'(redirect_valid), 32'd1);
    chk("ov_rpc", redirect_pc, 32'h8000_1180);
    step(); step();

    // AdES in delay slot
    ev(32'h8000_0010, 1, 7'b1000000, 32'h0000_0003, 0, 0, 0);
    @(negedge clk);
    chk("ades_epc", set_epc, 32'h8000_000C);
    chk("ades_bd", 32'(cause_bd), 32'd1);
    chk("ades_bv", badvaddr_out, 32'h0000_0003);
    chk("ades_bv_wr", 32'(badvaddr_wr), 32'd1);
    chk("ades_code", 32'(cause_exccode), 32'h05);
    step(); step();

    // interrupt beats RI and Sys
    ev(32'h8000_0040, 0, 7'b0001010, 32'h0, 0, 1, 0);
    @(negedge clk);
    chk("int_code", 32'(cause_exccode), 32'h00);
    chk("int_code_wr", 32'(cause_exccode_wr), 32'd1);
    step(); step();

    // nested exception under EXL: EPC/BD untouched
    ev(32'h8000_0080, 1, 7'b0010000, 32'h0, 0, 0, 1);
    @(negedge clk);
    chk("exl_set", 32'(set_status_exl), 32'd1);
    chk("exl_code_wr", 32'(cause_exccode_wr), 32'd1);
    chk("exl_epc_wr", 32'(epc_wr), 32'd0);
    chk("exl_bd_wr", 32'(cause_bd_wr), 32'd0);
    step(); step();
    status_exl = 0;

    // ERET with fetch stalling; an event during REDIR must be ignored
    redirect_ready = 0; epc_in = 32'hBFC0_0200;
    ev(32'h8000_00C0, 0, 7'b0, 32'h0, 1, 0, 0);
    @(negedge clk);
    chk("eret_clr", 32'(clr_status_exl), 32'd1);
    chk("eret_set", 32'(set_status_exl), 32'd0);
    step();
    mem_valid = 1; mem_exc = 7'b0000100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("eret_hold", 32'(redirect_valid), 32'd1);
      chk("eret_rpc", redirect_pc, 32'hBFC0_0200);
      if (i == 3) begin idle_in(); redirect_ready = 1; end
      step();
    end
    @(negedge clk);
    chk("eret_done", 32'(redirect_valid), 32'd0);
    step();

    // reset during REDIR, then a clean Sys event
    ev(32'h8000_0100, 0, 7'b0000100, 32'h0, 0, 0, 0);
    step();
    rst = 1;
    step();
    @(negedge clk);
    chk("rst2_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst2_flush", 32'(flush), 32'd0);
    chk("rst2_rpc", redirect_pc, 32'd0);
    chk("rst2_code", 32'(cause_exccode), 32'd0);
    rst = 0;
    ev(32'h8000_0200, 0, 7'b0001000, 32'h0, 0, 0, 0);
    @(negedge clk);
    chk("sys_flush", 32'(flush), 32'd1);
    chk("sys_code", 32'(cause_exccode), 32'h08);
    step(); step();

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      mem_valid      = ($urandom_range(0, 3) != 0);
      mem_exc        = ($urandom_range(0, 2) == 0) ? 7'($urandom) :
                       (($urandom_range(0, 2) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'b0);
      mem_eret       = ($urandom_range(0, 5) == 0);
      soft_break     = ($urandom_range(0, 9) == 0);
      hard_break     = ($urandom_range(0, 9) == 0);
      mem_in_ds      = 1'($urandom);
      mem_pc         = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      mem_badvaddr   = $urandom;
      status_exl     = 1'($urandom);
      epc_in         = $urandom;
      ebase_in       = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; idle_in();
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
Name: exc_commit

Overview:
- Exception commit controller at the MEM/WB boundary, directly upstream of the CP0 register file.
- Collects per-instruction exception flags and sampled interrupt requests, picks the winning cause by priority, and issues one-cycle write strobes to CP0 (EXL, Cause.BD, Cause.ExcCode, EPC, BadVAddr).
- Flushes the pipeline, then holds a redirect PC (exception vector or ERET target) until fetch accepts it.

Parameters:
EXC_OFFSET, 32'h0000_0180, offset added to ebase_in to form the general exception vector
EPC_ADJ, 32'd4, amount subtracted from the PC when the instruction is in a delay slot

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_valid  in  1  MEM-stage instruction valid
mem_pc  in  32  PC of the MEM-stage instruction
mem_in_ds  in  1  MEM-stage instruction is in a branch delay slot
mem_exc  in  7  flags {ades, adel_ld, bp, sys, ov, ri, adel_if}, bit 0 = adel_if
mem_badvaddr  in  32  faulting data address for adel_ld/ades
mem_eret  in  1  MEM-stage instruction is ERET
soft_break  in  1  CP0 software interrupt pending, already masked
hard_break  in  1  CP0 hardware interrupt pending, already masked
status_exl  in  1  CP0 Status.EXL
epc_in  in  32  CP0 EPC
ebase_in  in  32  CP0 Ebase
set_status_exl  out  1  CP0 strobe
clr_status_exl  out  1  CP0 strobe (ERET)
badvaddr_wr  out  1  CP0 strobe
badvaddr_out  out  32  BadVAddr data
cause_bd_wr  out  1  CP0 strobe
cause_bd  out  1  BD data
cause_exccode_wr  out  1  CP0 strobe
cause_exccode  out  5  ExcCode data
epc_wr  out  1  CP0 strobe
set_epc  out  32  EPC data
flush  out  1  flush IF..MEM, one cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts to IDLE with no further strobes.
- FSM states: IDLE, FLUSH, REDIR.
- IDLE:
  - An event occurs when mem_valid=1 and any of the following holds: (soft_break|hard_break), any mem_exc bit, or mem_eret.
  - On an event, at that edge register cause, BD, EPC, BadVAddr and target, then go to FLUSH.
  - mem_valid=0 means no event; pending interrupts wait for a valid instruction.
- Cause priority, highest first, ExcCode in hex:
  - Int 00
  - AdEL-fetch 04
  - RI 0A
  - Ov 0C
  - Sys 08
  - Bp 09
  - AdEL-load 04
  - AdES 05
  - ERET is taken only when no exception or interrupt is present.
- Captured values:
  - set_epc = mem_in_ds ? mem_pc-EPC_ADJ : mem_pc (32-bit wrap).
  - cause_bd = mem_in_ds.
  - badvaddr_out = mem_pc for AdEL-fetch, mem_badvaddr for AdEL-load/AdES; badvaddr_wr only for these three causes.
  - Exception target = ebase_in+EXC_OFFSET. ERET target = epc_in, sampled in the IDLE event cycle.
- FLUSH (exactly one cycle): flush=1.
  - Exception: set_status_exl=1, cause_exccode_wr=1.
  - Exception with status_exl=0 at capture: epc_wr=1, cause_bd_wr=1. With status_exl=1 at capture, EPC/BD strobes are suppressed.
  - ERET: clr_status_exl=1 only.
  - Next state REDIR.
- REDIR: redirect_valid=1, redirect_pc stable. When redirect_valid&redirect_ready, go to IDLE on the next edge (redirect_valid drops). Holds indefinitely while redirect_ready=0.
- During FLUSH/REDIR all mem_* inputs and interrupts are ignored; no new event is captured until back in IDLE.
- Latency:
  - Event in cycle N → strobes and flush in N+1.
  - redirect_valid from N+2.
  - Earliest next capture in the cycle after the handshake.
- All strobes are single-cycle pulses; data outputs are held from capture until the next capture.

Decomposition:
- exc_pkg: ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), FSM state encoding, mem_exc bit indices.
- Sub-module exc_prio: combinational priority encoder taking {int, mem_exc, eret} and returning taken, is_eret, exccode, bv_sel.

Test Plan:
- Ov at mem_pc=0xBFC00100, in_ds=0, EXL=0, ebase=0x80001000 → N+1: flush, exccode=0x0C, epc_wr, set_epc=0xBFC00100, bd=0, no badvaddr_wr. N+2: redirect_pc=0x80001180.
- AdES with mem_badvaddr=0x00000003, in_ds=1, pc=0x80000010 → set_epc=0x8000000C, cause_bd=1, badvaddr_out=0x00000003, exccode=0x05.
- hard_break=1 together with ri and sys set → exccode=0x00; ri/sys ignored.
- Exception with status_exl=1 → set_status_exl and cause_exccode_wr pulse; epc_wr=0, cause_bd_wr=0.
- ERET with epc_in=0xBFC00200 → clr_status_exl one cycle; redirect_pc=0xBFC00200; redirect_ready held low 3 cycles → redirect_valid stays 1, then IDLE the cycle after ready.
- Event, then rst asserted during REDIR → next cycle all outputs 0; a new sys event after reset is captured normally with exccode=0x08.
